multi_valid_tracker: RTL and testbench
======================================

Name: multi_valid_tracker

Overview:
- Parametrised, multi-channel successor to the single-bit set/clear data-valid flag.
- Each channel holds a saturating pending count, selectable per channel as either:
  - legacy flag mode (0/1, clear wins), or
  - counting mode (set increments, clear decrements).
- A round-robin valid/ready offer port hands pending channel IDs to a downstream consumer. Each acceptance consumes one pending unit.
- Sits between producer-side "data written" strobes and a DMA/consumer that services channels.

Parameters:
- NUM_CH, 4, number of channels (2..32).
- CNT_W, 3, per-channel counter width; MAX = 2^CNT_W-1.
- CH_W, $clog2(NUM_CH), width of the channel index (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_i  in  NUM_CH  per-channel set strobe (1-cycle pulse = one event).
- clr_i  in  NUM_CH  per-channel clear strobe.
- mode_i  in  NUM_CH  0 = flag mode, 1 = counting mode; quasi-static.
- err_clr_i  in  NUM_CH  write-1-to-clear for ovf_o/udf_o.
- valid_o  out  NUM_CH  per-channel cnt != 0.
- cnt_o  out  NUM_CH*CNT_W  packed per-channel counts; channel k at [k*CNT_W +: CNT_W].
- ovf_o  out  NUM_CH  sticky overflow.
- udf_o  out  NUM_CH  sticky underflow.
- out_valid_o  out  1  offer valid.
- out_ch_o  out  CH_W  offered channel.
- out_ready_i  in  1  consumer accept.

Behaviour:
- Reset (async, rst_n low): all counts 0, ovf_o/udf_o 0, out_valid_o 0, out_ch_o 0, RR pointer = NUM_CH-1, FSM in IDLE. The first grant after reset goes to channel 0.
- Per-channel update, every cycle. Let cons_k = 1 when the offer of channel k is accepted (FSM in OFFER, out_ch_o==k, out_valid_o & out_ready_i).
- Flag mode:
  - Priority: clr_i or cons_k -> 0; else set_i -> 1; else hold.
  - Set while already 1: no overflow.
  - Clear while 0: no underflow.
  - Behaviour is identical to the legacy flag.
- Counting mode:
  - next = cnt + set - clr - cons, evaluated in CNT_W+2 signed width.
  - If next > MAX: cnt = MAX, ovf sets.
  - If next < 0: cnt = 0, udf sets. This applies only when clr_i made it negative; consumption never underflows because the offer requires cnt != 0.
  - Simultaneous set+clr: net no change.
- Error flags:
  - ovf/udf are sticky.
  - An err_clr_i bit clears its flag; a new error in the same cycle wins (the flag stays 1).
- Mode change: only legal when cnt == 0. If flag mode is selected with cnt > 1, the flag-mode rules apply to the next event and nonzero is treated as 1.
- valid_o[k] = (cnt_k != 0), combinational from the registers, so it reflects the count one cycle after the strobe.
- Offer FSM (states IDLE, OFFER):
  - IDLE: if any valid_o, pick the first nonzero channel searching from RR pointer+1 upward with wrap. Register out_ch_o and go to OFFER. out_valid_o rises on the next cycle.
  - OFFER: out_valid_o = 1 and out_ch_o held stable.
  - Accept (out_ready_i=1): consume one unit, RR pointer = out_ch_o, return to IDLE.
  - Throughput is one grant per 2 cycles.
  - Withdrawal: if the offered channel's count reaches 0 through clr_i without acceptance, the FSM returns to IDLE next cycle and out_valid_o drops. This is the only case in which out_valid_o deasserts without a handshake.
  - If clr_i and acceptance hit the same cycle on a channel with cnt=1, next goes negative. The result saturates at 0 and udf sets (the clear had nothing left to clear).
- Latency: set strobe to out_valid_o = 2 cycles minimum (count register, then the IDLE pick).
- Reset mid-offer: out_valid_o drops immediately (asynchronous) and no consumption is recorded.

Decomposition:
- Package mvt_pkg:
  - state enum {IDLE, OFFER};
  - mode constants MODE_FLAG=0, MODE_CNT=1;
  - a function for the round-robin pick (mask + priority from pointer).
- Sub-module valid_counter_ch, one instance per channel via generate:
  - inputs: set, clr, cons, mode, err_clr;
  - outputs: cnt, ovf, udf.
- The top level holds the FSM, RR pointer and output packing.

Test Plan:
- Flag mode, NUM_CH=4, CNT_W=3:
  - set_i[1] at T0 -> valid_o[1]=1 at T1, out_valid_o=1 with out_ch_o=1 at T2.
  - set_i[1] and clr_i[1] together at T0 -> valid_o[1] stays 0.
- Counting mode, channel 2: 9 consecutive set pulses -> cnt=7 after the 7th. The 8th pulse sets ovf_o[2]=1 and cnt stays 7. err_clr_i[2] then clears ovf_o[2].
- Round robin: set channels 0, 2, 3 (count 1 each), out_ready_i held 1 -> grants in order 0, 2, 3, one every 2 cycles. All counts 0 afterwards and out_valid_o=0.
- Backpressure and withdrawal:
  - Channel 3 offered, out_ready_i=0 for 5 cycles -> out_ch_o stays 3 and out_valid_o stays 1.
  - clr_i[3] with cnt=1 -> out_valid_o=0 on the next cycle, FSM in IDLE.
- Underflow: counting mode, cnt[0]=1, offered, clr_i[0] and out_ready_i=1 in the same cycle -> cnt[0]=0, udf_o[0]=1.
- Reset mid-operation: assert rst_n=0 during OFFER with cnt[1]=5 -> all outputs 0 immediately. After release, the first grant is channel 0 once channel 0 is set.

Source files
------------

// File: rtl/mvt_pkg.sv
// Shared types, mode encodings and the round-robin channel picker for the
// multi-channel data-valid tracker.
package mvt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam logic MODE_FLAG = 1'b0;
  localparam logic MODE_CNT  = 1'b1;

  // First set bit of req[n-1:0], searching upward from ptr+1 with wrap.
  // Sized for the 32-channel maximum; n is a constant at every call site.
  function automatic logic [4:0] rr_pick(input logic [31:0] req,
                                         input logic [4:0]  ptr,
                                         input int          n);
    logic [4:0] pick;
    logic       found;
    logic [5:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i <= n) begin
        idx = 6'(int'(ptr) + i);
        if (idx >= 6'(n)) idx = idx - 6'(n);
        if (!found && req[idx[4:0]]) begin
          pick  = idx[4:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/valid_counter_ch.sv
// One channel of pending-work tracking: legacy set/clear flag or saturating
// up/down counter, with sticky overflow/underflow flags.
module valid_counter_ch
  import mvt_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             clr,
  input  logic             cons,
  input  logic             mode,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             udf,
  output logic             empty_next
);

  localparam logic signed [CNT_W+1:0] MAX_S = $signed((CNT_W+2)'((1 << CNT_W) - 1));

  logic signed [CNT_W+1:0] sum;
  logic [CNT_W-1:0]        cnt_next;
  logic                    ovf_evt;
  logic                    udf_evt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sum = $signed({2'b00, cnt}) + $signed((CNT_W+2)'(set))
        - $signed((CNT_W+2)'(clr)) - $signed((CNT_W+2)'(cons));
    cnt_next = cnt;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    if (mode == MODE_FLAG) begin
      // Clear and consumption beat set; any nonzero count behaves as 1.
      if (clr || cons)  cnt_next = '0;
      else if (set)     cnt_next = CNT_W'(1);
    end else if (sum > MAX_S) begin
      cnt_next = '1;
      ovf_evt  = 1'b1;
    end else if (sum < 0) begin
      cnt_next = '0;
      udf_evt  = 1'b1;
    end else begin
      cnt_next = sum[CNT_W-1:0];
    end
  end

  assign empty_next = (cnt_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      // A fresh error in the same cycle as its clear keeps the flag set.
      ovf <= (ovf & ~err_clr) | ovf_evt;
      udf <= (udf & ~err_clr) | udf_evt;
    end
  end

endmodule

// File: rtl/multi_valid_tracker.sv
// Multi-channel pending-work tracker with a round-robin valid/ready offer
// port that hands nonzero channel IDs to a downstream consumer.
module multi_valid_tracker
  import mvt_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 3,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       set_i,
  input  logic [NUM_CH-1:0]       clr_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]       err_clr_i,
  output logic [NUM_CH-1:0]       valid_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       udf_o,
  output logic                    out_valid_o,
  output logic [CH_W-1:0]         out_ch_o,
  input  logic                    out_ready_i
);

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] cons;
  logic [NUM_CH-1:0] empty_next;
  logic              accept;

  assign out_valid_o = (state == OFFER);
  assign accept      = out_valid_o & out_ready_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign cons[k]    = accept && (out_ch_o == CH_W'(k));
    assign valid_o[k] = (cnt_o[k*CNT_W +: CNT_W] != '0);

    valid_counter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .set        (set_i[k]),
      .clr        (clr_i[k]),
      .cons       (cons[k]),
      .mode       (mode_i[k]),
      .err_clr    (err_clr_i[k]),
      .cnt        (cnt_o[k*CNT_W +: CNT_W]),
      .ovf        (ovf_o[k]),
      .udf        (udf_o[k]),
      .empty_next (empty_next[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_ch_o <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|valid_o) begin
            out_ch_o <= CH_W'(rr_pick(32'(valid_o), 5'(rr_ptr), NUM_CH));
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            rr_ptr <= out_ch_o;
            state  <= IDLE;
          end else if (empty_next[out_ch_o]) begin
            // Offered channel drained by clear: withdraw the offer.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_valid_tracker.sv
// Directed bench for multi_valid_tracker: expected grants are queued when
// stimulus is driven and popped by a handshake monitor.
module tb_multi_valid_tracker;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 3;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       set_i, clr_i, mode_i, err_clr_i;
  logic [NUM_CH-1:0]       valid_o, ovf_o, udf_o;
  logic [NUM_CH*CNT_W-1:0] cnt_o;
  logic                    out_valid_o;
  logic [CH_W-1:0]         out_ch_o;
  logic                    out_ready_i;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  multi_valid_tracker #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (set_i),
    .clr_i       (clr_i),
    .mode_i      (mode_i),
    .err_clr_i   (err_clr_i),
    .valid_o     (valid_o),
    .cnt_o       (cnt_o),
    .ovf_o       (ovf_o),
    .udf_o       (udf_o),
    .out_valid_o (out_valid_o),
    .out_ch_o    (out_ch_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int k);
    return cnt_o[k*CNT_W +: CNT_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Handshake monitor: a grant is seen on the falling edge before it is taken.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL grant_unexpected: observed ch %0d, expected no grant", out_ch_o);
      end else begin
        check("grant_ch", 32'(out_ch_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    set_i = '0; clr_i = '0; mode_i = '0; err_clr_i = '0; out_ready_i = 1'b0;
    do_reset();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_cnt", 32'(cnt_o), 0);
    check("rst_err", 32'({ovf_o, udf_o}), 0);
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_out_ch", 32'(out_ch_o), 0);

    // Flag mode: set ch1 -> valid next cycle, offer the cycle after.
    exp_q.push_back(1);
    set_i = 4'b0010;
    step();
    set_i = '0;
    check("flag_valid_t1", 32'(valid_o), 32'h2);
    check("flag_offer_t1", 32'(out_valid_o), 0);
    step();
    check("flag_offer_t2", 32'(out_valid_o), 1);
    check("flag_ch_t2", 32'(out_ch_o), 1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("flag_consumed", 32'(valid_o), 0);
    check("flag_idle", 32'(out_valid_o), 0);

    // Flag mode: simultaneous set and clear leaves the flag clear.
    set_i = 4'b0010; clr_i = 4'b0010;
    step();
    set_i = '0; clr_i = '0;
    check("setclr_valid", 32'(valid_o), 0);
    step();
    check("setclr_no_offer", 32'(out_valid_o), 0);

    // Counting mode ch2: saturate at 7, overflow on the 8th pulse.
    mode_i = 4'b0100;
    for (int i = 1; i <= 9; i++) begin
      set_i = 4'b0100;
      step();
      check($sformatf("cnt_sat_%0d", i), 32'(cnt_of(2)), (i >= 7) ? 7 : i);
      check($sformatf("ovf_%0d", i), 32'(ovf_o[2]), (i >= 8) ? 1 : 0);
    end
    set_i = '0;
    err_clr_i = 4'b0100;
    step();
    err_clr_i = '0;
    check("ovf_cleared", 32'(ovf_o[2]), 0);
    check("cnt_after_errclr", 32'(cnt_of(2)), 7);
    clr_i = 4'b0100;
    repeat (7) step();
    clr_i = '0;
    check("cnt_drained", 32'(cnt_of(2)), 0);
    check("no_udf_drain", 32'(udf_o[2]), 0);
    check("drain_withdraw", 32'(out_valid_o), 0);
    mode_i = '0;

    // Round robin from a fresh pointer: 0, 2, 3, one grant per two cycles.
    do_reset();
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    set_i = 4'b1101;
    step();
    set_i = '0;
    out_ready_i = 1'b1;
    repeat (6) step();
    out_ready_i = 1'b0;
    check("rr_all_granted", 32'(exp_q.size()), 0);
    check("rr_counts_zero", 32'(cnt_o), 0);
    check("rr_idle", 32'(out_valid_o), 0);

    // Backpressure then withdrawal on ch3.
    set_i = 4'b1000;
    step();
    set_i = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid_o), 1);
      check("bp_ch", 32'(out_ch_o), 3);
      step();
    end
    clr_i = 4'b1000;
    step();
    clr_i = '0;
    check("withdraw_valid", 32'(out_valid_o), 0);
    check("withdraw_cnt", 32'(valid_o[3]), 0);

    // Underflow: clear and acceptance together on a count of 1.
    mode_i = 4'b0001;
    set_i = 4'b0001;
    step();
    set_i = '0;
    step();
    check("udf_offer_ch", 32'(out_ch_o), 0);
    check("udf_offer_valid", 32'(out_valid_o), 1);
    exp_q.push_back(0);
    clr_i = 4'b0001; out_ready_i = 1'b1;
    step();
    clr_i = '0; out_ready_i = 1'b0;
    check("udf_cnt", 32'(cnt_of(0)), 0);
    check("udf_flag", 32'(udf_o), 32'h1);
    check("udf_idle", 32'(out_valid_o), 0);
    err_clr_i = 4'b0001;
    step();
    err_clr_i = '0;
    check("udf_cleared", 32'(udf_o), 0);

    // Reset in the middle of an offer with cnt[1]=5.
    mode_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      set_i = 4'b0010;
      step();
    end
    set_i = '0;
    check("mid_cnt1", 32'(cnt_of(1)), 5);
    check("mid_offer", 32'({out_valid_o, out_ch_o}), 32'h5);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid_o), 0);
    check("arst_cnt", 32'(cnt_o), 0);
    check("arst_valid", 32'(valid_o), 0);
    check("arst_out_ch", 32'(out_ch_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode_i = '0;
    exp_q.push_back(0);
    set_i = 4'b0001;
    out_ready_i = 1'b1;
    step();
    set_i = '0;
    repeat (2) step();
    out_ready_i = 1'b0;
    check("post_rst_granted", 32'(exp_q.size()), 0);
    check("post_rst_cnt", 32'(cnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
